control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control sequencer for the 8-bit accumulator datapath. It consumes the 5-bit opcode held by the instruction register and drives that register's load/clear controls, plus the PC, MAR, accumulator, ALU and memory strobes. It runs a fetch/decode/execute FSM with a ready/strobe handshake toward memory and a bus-timeout watchdog.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive wait cycles (mem_ready=0) in any memory state before a bus error; 0 disables the watchdog.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  leave IDLE and begin fetching
- opcode  in  5  IR bits [7:3]
- zero  in  1  accumulator-zero flag from ALU
- mem_ready  in  1  memory completes current read/write this cycle
- ir_ena  out  1  IR load enable
- ir_sel  out  1  IR mux select: 0 = busC, 1 = clear to zero
- pc_inc  out  1  PC increment strobe
- pc_load  out  1  PC load-from-busC strobe
- mar_ld  out  1  MAR load-from-busC strobe
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request (data = accumulator)
- acc_ld  out  1  accumulator load from ALU
- alu_op  out  2  00 PASS busC, 01 ADD, 10 SUB
- halted  out  1  FSM in HALT
- illegal  out  1  sticky: illegal opcode trapped
- bus_err  out  1  sticky: memory watchdog expired

## Operation
- States: IDLE, FETCH, DECODE, EXEC0, EXEC1, HALT. Outputs are combinational from the state register, opcode, zero and mem_ready. Unlisted outputs are 0.
- Opcodes: 00000 NOP, 00001 LDI, 00010 ADD, 00011 SUB, 00100 JMP, 00101 JZ, 00110 STA, 11111 HLT. All others are illegal.
- IDLE: if start=1, go to FETCH.
- FETCH: mem_rd=1. When mem_ready=1: ir_ena=1, ir_sel=0, pc_inc=1, then go to DECODE.
- DECODE: no strobes.
  - NOP goes to FETCH.
  - HLT goes to HALT.
  - Illegal opcodes: see Configuration.
  - All others go to EXEC0.
- EXEC0: mem_rd=1. Strobes fire only in the cycle mem_ready=1:
  - LDI/ADD/SUB: acc_ld=1, pc_inc=1, alu_op=00/01/10, then FETCH.
  - JMP: pc_load=1, then FETCH.
  - JZ: if zero=1, pc_load=1; otherwise pc_inc=1. Then FETCH.
  - STA: mar_ld=1, pc_inc=1, then EXEC1.
- EXEC1 (STA only): mem_wr=1. When mem_ready=1, go to FETCH.
- HALT: halted=1, ir_ena=1, ir_sel=1 every cycle, so the IR holds NOP. Only rst leaves HALT; start is ignored.
- Stall rule: while mem_ready=0, mem_rd/mem_wr stay asserted. No other strobe fires and the state holds.
- Watchdog: a counter of width clog2(MEM_TIMEOUT+1) increments each cycle in FETCH/EXEC0/EXEC1 with mem_ready=0. It clears on mem_ready=1 or on any state change. When it equals MEM_TIMEOUT and mem_ready is still 0: set bus_err=1, go to HALT, and fire no strobes.
- mem_ready=1 in the same cycle the watchdog expires: the transfer completes normally and no error is raised.
- start outside IDLE is ignored.

## Timing
- Reset values: state IDLE, watchdog 0. halted, illegal and bus_err are 0. All strobes and alu_op are 0.
- rst asserted mid-instruction forces all outputs to these values immediately, asynchronously.
- With zero-wait memory:
  - NOP and HLT take 2 cycles (FETCH, DECODE).
  - LDI, ADD, SUB, JMP and JZ take 3 cycles.
  - STA takes 4 cycles.
- Each wait cycle adds 1 cycle to its state.
- IR update: the IR loads at the clock edge ending FETCH, so opcode is valid throughout DECODE.
- Strobes are single-cycle per transfer. pc_inc and pc_load are never both 1.

## Configuration
- CU_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE sets illegal=1 (sticky) and goes to HALT.
- Not defined: illegal opcodes execute as NOP (DECODE goes to FETCH), and illegal is tied to 0.

## Test plan
- Reset, start pulse, opcode=00000, mem_ready=1 -> FETCH/DECODE alternate; ir_ena=1 with ir_sel=0 and pc_inc=1 every 2nd cycle.
- opcode=00010 (ADD), mem_ready=1 -> in cycle 3: acc_ld=1, alu_op=01, pc_inc=1, mem_rd=1; next cycle is FETCH.
- JZ with zero=1 -> EXEC0 has pc_load=1, pc_inc=0. Repeat with zero=0 -> pc_inc=1, pc_load=0.
- STA with mem_ready=0 for 3 cycles in EXEC1 -> mem_wr=1 for 4 cycles, no other strobe; FETCH follows.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> after 15 wait cycles bus_err=1; next cycle halted=1, ir_ena=1, ir_sel=1; start is ignored.
- opcode=01010:
  - with CU_ILLEGAL_TRAP_EN -> illegal=1, halted=1.
  - without -> NOP timing, illegal=0.
  - In both cases, rst during EXEC1 returns the FSM to IDLE with all outputs 0.

Source files
------------

// File: rtl/control_unit_if.sv
// control_unit_if: sequencer bus; master = control_unit, slave = datapath/memory side
//   start, opcode, zero, mem_ready : status into the sequencer
//   ir_ena, ir_sel, pc_inc, pc_load, mar_ld, mem_rd, mem_wr, acc_ld, alu_op : strobes out
//   halted, illegal, bus_err : status flags out
interface control_unit_if;
  logic       start;
  logic [4:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_ena;
  logic       ir_sel;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_ld;
  logic       mem_rd;
  logic       mem_wr;
  logic       acc_ld;
  logic [1:0] alu_op;
  logic       halted;
  logic       illegal;
  logic       bus_err;
  modport master (
    input  start, opcode, zero, mem_ready,
    output ir_ena, ir_sel, pc_inc, pc_load, mar_ld, mem_rd, mem_wr, acc_ld, alu_op,
           halted, illegal, bus_err
  );
  modport slave (
    output start, opcode, zero, mem_ready,
    input  ir_ena, ir_sel, pc_inc, pc_load, mar_ld, mem_rd, mem_wr, acc_ld, alu_op,
           halted, illegal, bus_err
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 8-bit accumulator datapath
//   clk, rst (async, active-high); bus : control_unit_if.master (status in, strobes/flags out)
//   MEM_TIMEOUT : wait cycles tolerated per memory state before bus error (0 disables)
//   CU_ILLEGAL_TRAP_EN : when defined, illegal opcodes halt and set the sticky illegal flag
module control_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  control_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC0, EXEC1, HALT} state_t;
  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [4:0] OP_NOP = 5'd0, OP_LDI = 5'd1, OP_ADD = 5'd2, OP_SUB = 5'd3,
                         OP_JMP = 5'd4, OP_JZ = 5'd5, OP_STA = 5'd6, OP_HLT = 5'd31;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  state_t        state_q, state_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic          mem_st, expire, legal;
  assign mem_st = state_q inside {FETCH, EXEC0, EXEC1};
  assign expire = (MEM_TIMEOUT != 0) && mem_st && !bus.mem_ready && (wd_q == WW'(MEM_TIMEOUT));
  assign legal  = (bus.opcode <= OP_STA) || (bus.opcode == OP_HLT);
  // bus_err is visible in the expiring cycle itself; halted follows one cycle later
  assign bus.bus_err = bus_err_q | expire;
  assign bus.illegal = TRAP & illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q | expire;
    wd_d        = (mem_st && !bus.mem_ready && !expire) ? wd_q + 1'b1 : '0;
    bus.ir_ena  = 1'b0;
    bus.ir_sel  = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.pc_load = 1'b0;
    bus.mar_ld  = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.acc_ld  = 1'b0;
    bus.alu_op  = 2'b00;
    bus.halted  = 1'b0;
    case (state_q)
      IDLE: state_d = bus.start ? FETCH : IDLE;
      FETCH: begin
        bus.mem_rd = !expire;
        if (bus.mem_ready) begin
          bus.ir_ena = 1'b1;
          bus.pc_inc = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        state_d   = (bus.opcode == OP_NOP) ? FETCH :
                    (bus.opcode == OP_HLT) ? HALT :
                    !legal ? (TRAP ? HALT : FETCH) : EXEC0;
        illegal_d = illegal_q | (TRAP & !legal);
      end
      EXEC0: begin
        bus.mem_rd = !expire;
        if (bus.mem_ready) begin
          state_d = FETCH;
          case (bus.opcode)
            OP_LDI, OP_ADD, OP_SUB: begin
              bus.acc_ld = 1'b1;
              bus.pc_inc = 1'b1;
              bus.alu_op = (bus.opcode == OP_ADD) ? 2'b01 : (bus.opcode == OP_SUB) ? 2'b10 : 2'b00;
            end
            OP_JMP: bus.pc_load = 1'b1;
            OP_JZ: begin
              bus.pc_load = bus.zero;
              bus.pc_inc  = !bus.zero;
            end
            OP_STA: begin
              bus.mar_ld = 1'b1;
              bus.pc_inc = 1'b1;
              state_d    = EXEC1;
            end
            default: ;
          endcase
        end
      end
      EXEC1: begin
        bus.mem_wr = !expire;
        if (bus.mem_ready) state_d = FETCH;
      end
      HALT: begin
        bus.halted = 1'b1;
        bus.ir_ena = 1'b1;
        bus.ir_sel = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (expire) state_d = HALT;
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the control_unit sequencer
module tb_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  control_unit_if bus ();
  control_unit #(.MEM_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [12:0] IRE = 13'h1000, IRS = 13'h0800, PCI = 13'h0400, PCL = 13'h0200,
                          MAR = 13'h0100, RD  = 13'h0080, WR  = 13'h0040, ACC = 13'h0020,
                          AL1 = 13'h0010, AL0 = 13'h0008, HLT = 13'h0004, ILL = 13'h0002,
                          BER = 13'h0001, NONE = 13'h0000;
  logic [12:0] outs;
  assign outs = {bus.ir_ena, bus.ir_sel, bus.pc_inc, bus.pc_load, bus.mar_ld, bus.mem_rd,
                 bus.mem_wr, bus.acc_ld, bus.alu_op, bus.halted, bus.illegal, bus.bus_err};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic see(input string tag, input logic [12:0] exp);
    #1;
    n_cmp++;
    assert (outs === exp) else begin
      n_err++;
      $error("FAIL %s: outputs %h, expected %h", tag, outs, exp);
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.opcode = 5'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    see("reset", NONE);
    tick(); tick();
    rst = 1'b0;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;            see("nop_fetch", RD | IRE | PCI);
    tick();                              see("nop_decode", NONE);
    tick(); bus.opcode = 5'd2;           see("nop_fetch2", RD | IRE | PCI);
    tick();                              see("add_decode", NONE);
    tick();                              see("add_exec0", RD | ACC | PCI | AL0);
    tick(); bus.opcode = 5'd5; bus.zero = 1'b1; see("add_next_fetch", RD | IRE | PCI);
    tick(); tick();                      see("jz_taken", RD | PCL);
    tick(); bus.zero = 1'b0;
    tick(); tick();                      see("jz_not_taken", RD | PCI);
    tick(); bus.opcode = 5'd3;
    tick(); tick();                      see("sub_exec0", RD | ACC | PCI | AL1);
    tick(); bus.opcode = 5'd6;
    tick(); tick();                      see("sta_exec0", RD | MAR | PCI);
    tick(); bus.mem_ready = 1'b0;        see("sta_wait1", WR);
    tick();                              see("sta_wait2", WR);
    tick();                              see("sta_wait3", WR);
    tick(); bus.mem_ready = 1'b1;        see("sta_done", WR);
    tick(); bus.opcode = 5'd10;          see("sta_next_fetch", RD | IRE | PCI);
    tick();                              see("ill_decode", NONE);
    tick();
`ifdef CU_ILLEGAL_TRAP_EN
    see("ill_trap", IRE | IRS | HLT | ILL);
`else
    see("ill_as_nop", RD | IRE | PCI);
`endif
    rst = 1'b1;                          see("rst_async", NONE);
    tick(); rst = 1'b0; bus.start = 1'b1; bus.opcode = 5'd6;
    tick(); bus.start = 1'b0;
    tick(); tick(); tick(); bus.mem_ready = 1'b0; see("sta_exec1_again", WR);
    rst = 1'b1;                          see("rst_in_exec1", NONE);
    tick(); rst = 1'b0; bus.start = 1'b1; bus.opcode = 5'd31;
    tick(); bus.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      see("wd_boundary_wait", RD);
      tick();
    end
    bus.mem_ready = 1'b1;                see("wd_boundary_ready", RD | IRE | PCI);
    tick();                              see("hlt_decode", NONE);
    tick();                              see("hlt_halt", IRE | IRS | HLT);
    rst = 1'b1;
    tick(); rst = 1'b0; bus.start = 1'b1; bus.mem_ready = 1'b0;
    tick(); bus.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      see("wd_wait", RD);
      tick();
    end
    see("wd_expire", BER);
    tick(); bus.start = 1'b1;            see("wd_halt", IRE | IRS | HLT | BER);
    tick(); bus.mem_ready = 1'b1;        see("wd_halt_start_ignored", IRE | IRS | HLT | BER);
    tick();                              see("wd_halt_hold", IRE | IRS | HLT | BER);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
